// File: rtl/debouncer.sv
// Per-bit debouncer with a shared sample-tick generator and registered
// single-cycle rise/fall pulses for each debounced bit.
module debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int PW = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SW-1:0] SCNT_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_CNT_MAX - 1);

    logic [SW-1:0]             scnt_q, scnt_d;
    logic [WIDTH-1:0][PW-1:0]  pcnt_q, pcnt_d;
    logic [WIDTH-1:0]          deb_q, deb_d;
    logic [WIDTH-1:0]          rise_q, rise_d;
    logic [WIDTH-1:0]          fall_q, fall_d;
    logic                      tick;

    assign tick = (scnt_q == SCNT_LAST);

    always_comb begin
        scnt_d = tick ? '0 : scnt_q + 1'b1;
    end

    // Input is only observed on tick cycles; pulses default low every edge.
    always_comb begin
        pcnt_d = pcnt_q;
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (glitchy_signal[i] == deb_q[i]) begin
                    pcnt_d[i] = '0;
                end else if (pcnt_q[i] == PCNT_LAST) begin
                    deb_d[i]  = ~deb_q[i];
                    pcnt_d[i] = '0;
                    rise_d[i] = ~deb_q[i];
                    fall_d[i] = deb_q[i];
                end else begin
                    pcnt_d[i] = pcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q <= '0;
            pcnt_q <= '0;
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            scnt_q <= scnt_d;
            pcnt_q <= pcnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign debounced_signal = deb_q;
    assign rise_pulse       = rise_q;
    assign fall_pulse       = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: a run-length behavioural model checked every
// cycle, plus literal expectations at hand-computed edges.
module tb_debouncer;

    localparam int W = 2;
    localparam int S = 4;
    localparam int P = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] glitchy = '0;
    logic [W-1:0] deb, rise, fall;

    int checks = 0;
    int passes = 0;

    debouncer #(
        .WIDTH(W),
        .SAMPLE_CNT_MAX(S),
        .PULSE_CNT_MAX(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .glitchy_signal(glitchy),
        .debounced_signal(deb),
        .rise_pulse(rise),
        .fall_pulse(fall)
    );

    always #5 clk = ~clk;

    // Edge number since reset release; edge 1 is the first rising edge.
    int ecount;
    always @(posedge clk or posedge rst) begin
        if (rst) ecount = 0;
        else     ecount = ecount + 1;
    end

    // Model: every S-th edge samples the input; P consecutive differing
    // samples flip the level and raise the matching pulse for one cycle.
    logic [W-1:0] m_deb, m_rise, m_fall;
    int           m_run [W];
    int           m_n;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_deb = '0; m_rise = '0; m_fall = '0; m_n = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_n    = m_n + 1;
            m_rise = '0;
            m_fall = '0;
            if (m_n % S == 0) begin
                for (int i = 0; i < W; i++) begin
                    if (glitchy[i] != m_deb[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == P) begin
                            m_deb[i] = ~m_deb[i];
                            m_run[i] = 0;
                            if (m_deb[i]) m_rise[i] = 1'b1;
                            else          m_fall[i] = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("model_deb", deb, m_deb);
        check("model_rise", rise, m_rise);
        check("model_fall", fall, m_fall);
    end

    // Advance to 1 time unit after rising edge k (counted from reset release).
    task automatic at_edge(input int k);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (ecount < k && guard < 500);
        if (ecount != k) begin
            checks++;
            $display("FAIL edge_wait: got edge %0d, expected %0d", ecount, k);
        end
    endtask

    initial begin
        // Reset held with both inputs high: nothing may move.
        glitchy = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("reset_deb", deb, 2'b00);
        check("reset_rise", rise, 2'b00);
        rst = 1'b0;

        at_edge(11);
        check("rst_rel_e11_deb", deb, 2'b00);
        at_edge(12);
        check("rst_rel_e12_deb", deb, 2'b11);
        check("rst_rel_e12_rise", rise, 2'b11);
        at_edge(13);
        check("rst_rel_e13_rise", rise, 2'b00);

        // Clean release: first low sample at edge 16, flip at edge 24.
        glitchy = 2'b00;
        at_edge(23);
        check("fall_e23_deb", deb, 2'b11);
        at_edge(24);
        check("fall_e24_deb", deb, 2'b00);
        check("fall_e24_fall", fall, 2'b11);

        // Bounce on bit 0: high at 28,32, low at 36, high from 40 -> flip at 48.
        glitchy = 2'b01;
        at_edge(32);
        glitchy = 2'b00;
        at_edge(36);
        glitchy = 2'b01;
        at_edge(47);
        check("bounce_e47_deb", deb, 2'b00);
        at_edge(48);
        check("bounce_e48_deb", deb, 2'b01);
        check("bounce_e48_rise", rise, 2'b01);

        // Sub-tick glitch on bit 1, never present at a sampling edge.
        at_edge(49);
        glitchy = 2'b11;
        at_edge(51);
        glitchy = 2'b01;
        at_edge(60);
        check("glitch_e60_deb", deb, 2'b01);

        // Reach debounced=10, then flip both bits in opposite directions.
        glitchy = 2'b10;
        at_edge(72);
        check("indep_setup_deb", deb, 2'b10);
        glitchy = 2'b01;
        at_edge(84);
        check("indep_deb", deb, 2'b01);
        check("indep_rise", rise, 2'b01);
        check("indep_fall", fall, 2'b10);

        // Two differing samples (88, 92), then a half-cycle async reset.
        glitchy = 2'b10;
        at_edge(92);
        rst = 1'b1;
        #1;
        check("async_rst_deb", deb, 2'b00);
        check("async_rst_fall", fall, 2'b00);
        #4;
        rst = 1'b0;
        at_edge(11);
        check("after_rst_e11_deb", deb, 2'b00);
        at_edge(12);
        check("after_rst_e12_deb", deb, 2'b10);
        check("after_rst_e12_rise", rise, 2'b10);
        at_edge(16);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/debouncer.md
# debouncer

Per-bit debouncer and edge detector for the io_circuits path. It sits directly downstream of the 2-flop synchronizer and consumes the synchronized button and switch vector. A bit's stable output changes only after the input has held a new level for PULSE_CNT_MAX consecutive sample ticks. The block also emits single-cycle rise and fall pulses, which the user-I/O logic in the top level consumes.

## Interface
- WIDTH, 1: number of independent input bits.
- SAMPLE_CNT_MAX, 62500: clock cycles per sample tick; legal range is ≥1.
- PULSE_CNT_MAX, 200: consecutive differing ticks required to flip a bit; legal range is ≥1.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- glitchy_signal  input  WIDTH  synchronized but bouncing inputs from the synchronizer.
- debounced_signal  output  WIDTH  stable level per bit.
- rise_pulse  output  WIDTH  one-cycle pulse when the matching debounced bit goes 0→1.
- fall_pulse  output  WIDTH  one-cycle pulse when the matching debounced bit goes 1→0.

## Operation
- Sample tick generator:
  - Shared counter `scnt`, width $clog2(SAMPLE_CNT_MAX) with a minimum of 1.
  - Counts 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - `tick` = (scnt == SAMPLE_CNT_MAX-1), combinational.
  - SAMPLE_CNT_MAX=1 gives tick on every cycle.
- Per-bit saturating counter `pcnt[i]`, width $clog2(PULSE_CNT_MAX+1). On a clock edge with tick=1:
  - If glitchy_signal[i] equals debounced_signal[i]: pcnt[i] ← 0.
  - Else if pcnt[i] == PULSE_CNT_MAX-1:
    - debounced_signal[i] toggles.
    - pcnt[i] ← 0.
    - rise_pulse[i] ← new value; fall_pulse[i] ← !new value.
  - Else: pcnt[i] ← pcnt[i]+1.
- On a clock edge with tick=0:
  - pcnt[i] and debounced_signal[i] hold.
- rise_pulse and fall_pulse:
  - Registered and cleared on every edge unless set by the flip rule above.
  - Never high for two consecutive cycles.
  - Never both high for the same bit.
- Bits are fully independent. Only the tick generator is shared.
- Input is looked at only on tick cycles. Level changes between ticks are invisible.

## Timing
- Reset values:
  - scnt=0, pcnt=0.
  - debounced_signal=0, rise_pulse=0, fall_pulse=0.
- Reset asserted mid-operation:
  - All state clears immediately, with no clock required.
  - Any partially counted bounce is discarded.
  - An in-flight pulse is dropped.
- Cycle numbering: cycle 1 is the first rising edge after rst deasserts.
  - The first tick is active during the cycle in which scnt = SAMPLE_CNT_MAX-1.
  - That tick is consumed at edge SAMPLE_CNT_MAX.
  - Later ticks are consumed every SAMPLE_CNT_MAX edges.
- Flip latency: debounced_signal and the matching pulse update together at the edge that consumes the PULSE_CNT_MAX-th consecutive differing tick. Worst-case latency from a clean input change to output is PULSE_CNT_MAX×SAMPLE_CNT_MAX cycles.
- A single matching sample during a bounce resets the count. The required run restarts from zero.
- Pulse width is exactly 1 clk cycle. The pulse is high in the same cycle as debounced_signal's first cycle at the new level.
- Counter arithmetic is unsigned. pcnt never exceeds PULSE_CNT_MAX-1. The scnt wrap is exact, with no off-by-one drift.

## Test plan
Parameters for all scenarios: SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2.

- **Reset values:** hold rst=1, drive glitchy=2'b11 → debounced=0 and pulses=0 throughout. After release, debounced[0] rises at edge 12 with rise_pulse[0]=1 for that cycle only.
- **Clean press:** glitchy[0]=1 from cycle 1 → debounced[0]=1 at edge 12, rise_pulse[0]=1 for one cycle. Then glitchy[0]=0 → fall_pulse[0]=1 exactly 3 ticks after the first low sample.
- **Bounce rejection:** glitchy[0] high for 2 ticks, low for 1 tick, then high steadily → no flip until the 3rd consecutive high tick after the low. Exactly one rise_pulse.
- **Sub-tick glitch:** glitchy[1] pulses high for 2 cycles strictly between ticks → debounced[1] stays 0 and no pulses.
- **Independence:** bit 0 rises while bit 1 falls, starting from debounced=2'b10 → rise_pulse=2'b01 and fall_pulse=2'b10 in the same cycle.
- **Async reset mid-count:** assert rst for half a cycle after 2 differing ticks → state clears without a clock edge. A subsequent flip needs the full 3 ticks again.
